bcd_convert_arbiter: RTL and testbench

Shares one iterative (one shift per clock) double-dabble binary-to-BCD engine between N_REQ requesting KPN processes.
- Arbitration is round-robin: it picks one pending request, runs the 16 shift/add-3 iterations, then holds the 5-digit BCD result with the requester's ID until the consumer accepts it.
- It replaces per-process combinational converters, trading latency for area.

---
 rtl/bcd_convert_arbiter_if.sv | 22 ++
 rtl/bcd_convert_arbiter.sv | 89 ++++++++
 tb/tb_bcd_convert_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_arbiter_if.sv
// bcd_convert_arbiter_if: requester and consumer handshake bundle for the shared BCD converter.
interface bcd_convert_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [16*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic [19:0]         rsp_bcd;
    logic [ID_W-1:0]     rsp_id;
    logic                rsp_ready;
    logic                busy;
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_bcd, rsp_id, busy
    );
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_bcd, rsp_id, busy
    );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin shared double-dabble binary-to-BCD engine, one shift per clock.
module bcd_convert_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int BIN_W = 16
) (
    input logic clk,
    input logic reset,
    bcd_convert_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d, id_q, id_d, gnt_idx, idx;
    logic [3:0]       cnt_q, cnt_d;
    logic [35:0]      sr_q, sr_d, sr_adj;
    logic [19:0]      bcd_q, bcd_d;
    logic [BIN_W-1:0] gnt_data;
    logic             gnt_any;
    // Scan from the lowest-priority offset down so the closest valid requester to ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx = '0;
        gnt_data = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        for (int j = 0; j < N_REQ; j++)
            if (ID_W'(j) == gnt_idx) gnt_data = bus.req_data[16*j +: 16];
    end
    for (genvar k = 0; k < 5; k++) begin : g_adj
        assign sr_adj[16+4*k +: 4] = sr_q[16+4*k +: 4] >= 4'd5 ? sr_q[16+4*k +: 4] + 4'd3 : sr_q[16+4*k +: 4];
    end
    assign sr_adj[15:0] = sr_q[15:0];
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        id_d = id_q;
        cnt_d = cnt_q;
        sr_d = sr_q;
        bcd_d = bcd_q;
        bus.req_ready = '0;
        case (state_q)
            IDLE: if (gnt_any) begin
                bus.req_ready[gnt_idx] = 1'b1;
                sr_d = {20'b0, gnt_data};
                id_d = gnt_idx;
                ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
                cnt_d = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d = {sr_adj[34:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    bcd_d = sr_adj[34:15];
                    state_d = DONE;
                end
            end
            DONE: state_d = bus.rsp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            id_q <= '0;
            cnt_q <= '0;
            sr_q <= '0;
            bcd_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            id_q <= id_d;
            cnt_q <= cnt_d;
            sr_q <= sr_d;
            bcd_q <= bcd_d;
        end
    end
    assign bus.rsp_valid = state_q == DONE;
    assign bus.busy = state_q != IDLE;
    assign bus.rsp_bcd = bcd_q;
    assign bus.rsp_id = id_q;
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: directed checks of grant order, latency, BCD results, backpressure and reset.
module tb_bcd_convert_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int n;
    time t_prev;
    logic [19:0] fair_exp [4] = '{20'h00011, 20'h00022, 20'h00033, 20'h00044};

    bcd_convert_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();
    bcd_convert_arbiter #(.N_REQ(N), .ID_W(2), .BIN_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Called just after the grant edge has been set up; counts negedges from the grant sample.
    task automatic await_rsp(input string tag, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.rsp_valid && cnt < 40);
        check({tag, "_lat"}, cnt, 17);
    endtask

    task automatic run_one(input int r, input logic [15:0] v, input logic [19:0] exp, input string tag);
        int c;
        @(negedge clk);
        bus.req_data[16*r +: 16] = v;
        bus.req_valid = 4'(1 << r);
        #1;
        check({tag, "_gnt"}, bus.req_ready, 1 << r);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        await_rsp(tag, c);
        check({tag, "_bcd"}, bus.rsp_bcd, exp);
        check({tag, "_id"}, bus.rsp_id, r);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drop"}, {bus.rsp_valid, bus.busy}, 0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.rsp_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_state", {bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_bcd}, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.req_data = {16'd44, 16'd33, 16'd22, 16'd11};
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        #1;
        for (int j = 0; j < 5; j++) begin
            n = 0;
            while (bus.req_ready == 0 && n < 40) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("fair_gnt", bus.req_ready, 1 << (j % 4));
            if (j > 0) check("fair_space", 32'(($time - t_prev) / 10), 18);
            t_prev = $time;
            if (j == 4) begin
                @(posedge clk);
                #1;
                bus.req_valid = '0;
            end
            await_rsp("fair", n);
            check("fair_bcd", bus.rsp_bcd, fair_exp[j % 4]);
            check("fair_id", bus.rsp_id, j % 4);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        run_one(0, 16'd1234, 20'h01234, "single");
        run_one(2, 16'd0, 20'h00000, "b0");
        run_one(2, 16'd9, 20'h00009, "b9");
        run_one(2, 16'd10, 20'h00010, "b10");
        run_one(2, 16'd9999, 20'h09999, "b9999");
        run_one(2, 16'd65535, 20'h65535, "b65535");

        @(negedge clk);
        bus.req_data[15:0] = 16'd4321;
        bus.req_valid = 4'b0001;
        #1;
        check("bp_gnt", bus.req_ready, 4'b0001);
        @(posedge clk);
        #1;
        bus.req_data[31:16] = 16'd777;
        bus.req_valid = 4'b0010;
        await_rsp("bp", n);
        for (int j = 0; j < 10; j++) begin
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_bcd", bus.rsp_bcd, 20'h04321);
            check("bp_id", bus.rsp_id, 0);
            check("bp_hold", bus.req_ready, 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_handoff", bus.req_ready, 0);
        @(negedge clk);
        #1;
        check("bp_regnt", {bus.rsp_valid, bus.req_ready}, 5'b00010);
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        await_rsp("bp2", n);
        check("bp2_bcd", bus.rsp_bcd, 20'h00777);
        check("bp2_id", bus.rsp_id, 1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        bus.req_data[63:48] = 16'd5555;
        bus.req_valid = 4'b1000;
        #1;
        check("mr_gnt", bus.req_ready, 4'b1000);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (8) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mr_out", {bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_bcd}, 0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.busy) n++;
        end
        check("mr_quiet", n, 0);
        bus.req_data[31:16] = 16'd100;
        bus.req_data[63:48] = 16'd300;
        bus.req_valid = 4'b1010;
        #1;
        check("mr_prio", bus.req_ready, 4'b0010);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        await_rsp("mr", n);
        check("mr_bcd", bus.rsp_bcd, 20'h00100);
        check("mr_id", bus.rsp_id, 1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        for (int j = 0; j < 20; j++) begin
            int r;
            int v;
            r = int'($urandom_range(3));
            v = int'($urandom_range(65535));
            run_one(r, 16'(v), to_bcd(v), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
